bench_decoder_driver: RTL and testbench

- Self-contained stimulus and observation harness for the 2D planar-code decoder, used in resource and throughput builds.
- Generates syndromes from a seeded LFSR, or takes them from an external source, and sequences the decoder stage bus through load, grow and sync.
- Detects when clusters have converged, counts iterations and cycles, and folds every round's result into a 32-bit MISR signature.
- Replaces the single-shot XOR-compressed wrapper with a multi-round, parametrised, self-checking driver.

---
 rtl/bench_decoder_driver_if.sv | 12 +
 rtl/bench_decoder_driver.sv | 171 +++++++++++++++++
 tb/tb_bench_decoder_driver.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/bench_decoder_driver_if.sv
// Stage bus between the bench driver (master) and the planar-code decoder (slave).
interface bench_decoder_driver_if #(
  parameter int unsigned PU_COUNT    = 20,
  parameter int unsigned STAGE_WIDTH = 2
);
  logic [STAGE_WIDTH-1:0] stage;
  logic [PU_COUNT-1:0]    is_error_syndromes;
  logic [PU_COUNT-1:0]    is_odd_clusters;

  modport master (output stage, output is_error_syndromes, input is_odd_clusters);
  modport slave  (input stage, input is_error_syndromes, output is_odd_clusters);
endinterface

// File: rtl/bench_decoder_driver.sv
// Multi-round stimulus driver for the planar-code decoder: LFSR or external syndromes,
// load/grow/sync sequencing, convergence detection and a 32-bit MISR over round results.
module bench_decoder_driver #(
  parameter int unsigned CODE_DISTANCE = 5,
  parameter int unsigned STAGE_WIDTH   = 2,
  parameter int unsigned ROUNDS_WIDTH  = 16,
  parameter int unsigned MAX_ITER      = 2 * CODE_DISTANCE,
  parameter int unsigned DENSITY_SHIFT = 2,
  parameter logic [31:0] LFSR_SEED     = 32'hACE1_0001
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       start,
  input  logic [ROUNDS_WIDTH-1:0]                    num_rounds,
  input  logic                                       use_ext,
  input  logic [CODE_DISTANCE*(CODE_DISTANCE-1)-1:0] ext_syndromes,
  bench_decoder_driver_if.master                     dec,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       timeout,
  output logic [31:0]                                signature,
  output logic [ROUNDS_WIDTH-1:0]                    round_count,
  output logic [31:0]                                cycle_count
);
  localparam int unsigned PU_COUNT = CODE_DISTANCE * (CODE_DISTANCE - 1);
  localparam int unsigned ITER_W   = $clog2(MAX_ITER + 1);
  localparam int unsigned FILL_W   = (PU_COUNT > 1) ? $clog2(PU_COUNT) : 1;
  localparam logic [31:0] POLY     = 32'h8020_0003;
  localparam logic [31:0] DENSITY_MASK =
    (DENSITY_SHIFT == 0) ? 32'd1 : (32'hFFFF_FFFF >> (32 - DENSITY_SHIFT));

  localparam logic [STAGE_WIDTH-1:0] STG_IDLE   = STAGE_WIDTH'(0);
  localparam logic [STAGE_WIDTH-1:0] STG_SPREAD = STAGE_WIDTH'(1);
  localparam logic [STAGE_WIDTH-1:0] STG_SYNC   = STAGE_WIDTH'(2);
  localparam logic [STAGE_WIDTH-1:0] STG_LOAD   = STAGE_WIDTH'(3);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_LOAD, S_GROW, S_SYNC, S_CHECK, S_ZERO, S_DONE
  } state_t;

  state_t                  state;
  logic [31:0]             lfsr;
  logic [FILL_W-1:0]       fill_cnt;
  logic [ITER_W-1:0]       iter;
  logic [ROUNDS_WIDTH-1:0] num_rounds_q;
  logic                    use_ext_q;

  logic [31:0]             lfsr_next;
  logic                    fill_bit;
  logic                    converged;
  logic [ROUNDS_WIDTH-1:0] round_next;
  logic [31:0]             sig_next;

  always_comb begin
    lfsr_next  = lfsr[0] ? ((lfsr >> 1) ^ POLY) : (lfsr >> 1);
    // Bits outside the density window are forced high so the AND only sees the window.
    fill_bit   = &(lfsr | ~DENSITY_MASK);
    converged  = (dec.is_odd_clusters == '0);
    round_next = round_count + ROUNDS_WIDTH'(1);
    sig_next   = {signature[30:0], signature[31]} ^
                 {^dec.is_odd_clusters, 23'b0, 8'(iter)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                  <= S_IDLE;
      lfsr                   <= LFSR_SEED;
      fill_cnt               <= '0;
      iter                   <= '0;
      num_rounds_q           <= '0;
      use_ext_q              <= 1'b0;
      dec.stage              <= STG_IDLE;
      dec.is_error_syndromes <= '0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      timeout                <= 1'b0;
      signature              <= '0;
      round_count            <= '0;
      cycle_count            <= '0;
    end else begin
      if (state != S_IDLE && state != S_DONE && cycle_count != '1)
        cycle_count <= cycle_count + 32'd1;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            signature    <= '0;
            round_count  <= '0;
            cycle_count  <= '0;
            timeout      <= 1'b0;
            lfsr         <= LFSR_SEED;
            busy         <= 1'b1;
            done         <= 1'b0;
            num_rounds_q <= num_rounds;
            use_ext_q    <= use_ext;
            if (num_rounds == '0) begin
              state <= S_ZERO;
            end else if (use_ext) begin
              state     <= S_LOAD;
              dec.stage <= STG_LOAD;
            end else begin
              state    <= S_FILL;
              fill_cnt <= '0;
            end
          end
        end

        S_ZERO: begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end

        S_FILL: begin
          dec.is_error_syndromes <= {dec.is_error_syndromes[PU_COUNT-2:0], fill_bit};
          lfsr                   <= lfsr_next;
          if (fill_cnt == FILL_W'(PU_COUNT - 1)) begin
            state     <= S_LOAD;
            dec.stage <= STG_LOAD;
          end else begin
            fill_cnt <= fill_cnt + FILL_W'(1);
          end
        end

        S_LOAD: begin
          if (use_ext_q)
            dec.is_error_syndromes <= ext_syndromes;
          iter      <= '0;
          state     <= S_GROW;
          dec.stage <= STG_SPREAD;
        end

        S_GROW: begin
          iter      <= iter + ITER_W'(1);
          state     <= S_SYNC;
          dec.stage <= STG_SYNC;
        end

        S_SYNC: begin
          state     <= S_CHECK;
          dec.stage <= STG_IDLE;
        end

        S_CHECK: begin
          if (!converged && iter != ITER_W'(MAX_ITER)) begin
            state     <= S_GROW;
            dec.stage <= STG_SPREAD;
          end else begin
            if (!converged)
              timeout <= 1'b1;
            signature   <= sig_next;
            round_count <= round_next;
            if (round_next == num_rounds_q) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (use_ext_q) begin
              state     <= S_LOAD;
              dec.stage <= STG_LOAD;
            end else begin
              state    <= S_FILL;
              fill_cnt <= '0;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bench_decoder_driver.sv
// Directed bench for bench_decoder_driver: external and LFSR rounds, timeout, reset abort,
// zero-round runs, plus a second instance exercising the density-window fill.
module tb_bench_decoder_driver;
  localparam int unsigned D    = 5;
  localparam int unsigned PU   = D * (D - 1);
  localparam logic [31:0] SEED = 32'hACE1_0001;

  logic          clk;
  logic          reset;
  logic          start, start2;
  logic [15:0]   num_rounds;
  logic          use_ext;
  logic [PU-1:0] ext_syndromes;
  logic          busy, done, timeout;
  logic [31:0]   signature, cycle_count;
  logic [15:0]   round_count;
  logic          busy2, done2, timeout2;
  logic [31:0]   signature2, cycle_count2;
  logic [15:0]   round_count2;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  bench_decoder_driver_if #(.PU_COUNT(PU), .STAGE_WIDTH(2)) bus  ();
  bench_decoder_driver_if #(.PU_COUNT(PU), .STAGE_WIDTH(2)) bus2 ();

  bench_decoder_driver #(.CODE_DISTANCE(D), .DENSITY_SHIFT(0)) dut (
    .clk(clk), .reset(reset), .start(start), .num_rounds(num_rounds),
    .use_ext(use_ext), .ext_syndromes(ext_syndromes), .dec(bus),
    .busy(busy), .done(done), .timeout(timeout), .signature(signature),
    .round_count(round_count), .cycle_count(cycle_count)
  );

  bench_decoder_driver #(.CODE_DISTANCE(D), .DENSITY_SHIFT(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .num_rounds(num_rounds),
    .use_ext(use_ext), .ext_syndromes(ext_syndromes), .dec(bus2),
    .busy(busy2), .done(done2), .timeout(timeout2), .signature(signature2),
    .round_count(round_count2), .cycle_count(cycle_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_stage"}, bus.stage, 0);
    check({tag, "_syn"}, bus.is_error_syndromes, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_sig"}, signature, 0);
    check({tag, "_rounds"}, round_count, 0);
    check({tag, "_cycles"}, cycle_count, 0);
  endtask

  // LFSR-fill run of 3 rounds; the decoder model reports syn >> (2k) at the k-th CHECK.
  task automatic run_lfsr(input int unsigned stop_grow, input logic with2);
    logic [31:0]   m;
    logic [PU-1:0] syn, syn2;
    logic [31:0]   esig;
    int unsigned   ecyc, k, kexp, zeros, grows, round;
    m = SEED; syn = '0; syn2 = '0; esig = '0; ecyc = 0;
    k = 0; zeros = 0; grows = 0; round = 0;
    use_ext = 1'b0; num_rounds = 16'd3; bus.is_odd_clusters = '0;
    start = 1'b1; start2 = with2;
    tick();
    start = 1'b0; start2 = 1'b0;
    check("lfsr_busy", busy, 1);
    check("lfsr_timeout_clr", timeout, 0);
    for (int unsigned cyc = 0; cyc < 3000 && !done; cyc++) begin
      case (bus.stage)
        2'd0: zeros++;
        2'd3: begin
          for (int unsigned i = 0; i < PU; i++) begin
            syn  = {syn[PU-2:0], m[0]};
            syn2 = {syn2[PU-2:0], m[1] & m[0]};
            m    = lfsr_step(m);
          end
          check("fill_len", zeros, (round == 0) ? PU : PU + 1);
          check("lfsr_syn", bus.is_error_syndromes, 32'(syn));
          if (round == 0 && with2)
            check("lfsr_syn_ds2", bus2.is_error_syndromes, 32'(syn2));
          kexp = 1;
          while (kexp < 2 * D && (syn >> (2 * kexp)) != '0) kexp++;
          esig = {esig[30:0], esig[31]} ^ kexp;
          ecyc += PU + 1 + 3 * kexp;
          zeros = 0; k = 0; round++;
        end
        2'd1: begin
          zeros = 0;
          grows++;
          if (grows == stop_grow) return;
        end
        2'd2: begin
          k++;
          bus.is_odd_clusters = syn >> (2 * k);
        end
        default: ;
      endcase
      tick();
    end
    check("lfsr_done", done, 1);
    check("lfsr_busy_end", busy, 0);
    check("lfsr_rounds", round_count, 3);
    check("lfsr_sig", signature, esig);
    check("lfsr_cycles", cycle_count, ecyc);
    check("lfsr_timeout", timeout, 0);
  endtask

  initial begin
    int unsigned exp1 [4]  = '{3, 1, 2, 0};
    int unsigned exp2 [10] = '{3, 1, 2, 0, 1, 2, 0, 1, 2, 0};

    reset = 1'b1; start = 1'b0; start2 = 1'b0; num_rounds = '0;
    use_ext = 1'b0; ext_syndromes = '0;
    bus.is_odd_clusters = '0; bus2.is_odd_clusters = '0;
    tick(); tick();
    check_cleared("reset");
    reset = 1'b0;
    tick();
    check_cleared("idle");

    // Case 1: external zero syndromes, immediate convergence.
    use_ext = 1'b1; ext_syndromes = '0; num_rounds = 16'd1;
    start = 1'b1; tick(); start = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_done_low", done, 0);
    for (int i = 0; i < 4; i++) begin
      check("t1_stage", bus.stage, exp1[i]);
      tick();
    end
    check("t1_done", done, 1);
    check("t1_busy_end", busy, 0);
    check("t1_sig", signature, 32'h0000_0001);
    check("t1_rounds", round_count, 1);
    check("t1_cycles", cycle_count, 4);
    check("t1_timeout", timeout, 0);

    // Case 2: two odd CHECKs then convergence; a start pulse mid-run must be ignored.
    use_ext = 1'b1; ext_syndromes = 20'hA5C3F; num_rounds = 16'd1;
    bus.is_odd_clusters = 20'h00100;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("t2_stage", bus.stage, exp2[i]);
      if (i == 1) check("t2_ext_syn", bus.is_error_syndromes, 20'hA5C3F);
      if (i == 4) begin start = 1'b1; num_rounds = '0; use_ext = 1'b0; end
      if (i == 5) begin start = 1'b0; num_rounds = 16'd1; use_ext = 1'b1; end
      if (i == 7) bus.is_odd_clusters = '0;
      tick();
    end
    check("t2_done", done, 1);
    check("t2_sig", signature, 32'h0000_0003);
    check("t2_rounds", round_count, 1);
    check("t2_cycles", cycle_count, 10);

    // Case 3: never converges; times out after 10 GROWs with odd parity.
    ext_syndromes = 20'h00001; bus.is_odd_clusters = 20'h00001;
    start = 1'b1; tick(); start = 1'b0;
    check("t3_stage_load", bus.stage, 3);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("t3_stage_grow", bus.stage, 1);
      tick();
      check("t3_stage_sync", bus.stage, 2);
      tick();
      check("t3_stage_check", bus.stage, 0);
      tick();
    end
    check("t3_timeout", timeout, 1);
    check("t3_sig", signature, 32'h8000_000A);
    check("t3_done", done, 1);
    check("t3_rounds", round_count, 1);
    check("t3_cycles", cycle_count, 31);
    bus.is_odd_clusters = '0;

    // Case 4: LFSR fill, 3 rounds; second instance uses a 2-bit density window.
    run_lfsr(0, 1'b1);
    check("ds2_done", done2, 1);
    check("ds2_busy", busy2, 0);
    check("ds2_rounds", round_count2, 3);
    check("ds2_sig", signature2, 32'h0000_0007);
    check("ds2_cycles", cycle_count2, 72);
    check("ds2_timeout", timeout2, 0);

    // Case 5: reset during the second GROW aborts; start with reset is ignored.
    run_lfsr(2, 1'b0);
    reset = 1'b1;
    tick();
    check_cleared("abort");
    start = 1'b1;
    tick();
    check("rst_wins_busy", busy, 0);
    check("rst_wins_stage", bus.stage, 0);
    start = 1'b0; reset = 1'b0;
    tick();
    check("post_rst_busy", busy, 0);
    run_lfsr(0, 1'b0);

    // Case 6: zero rounds finishes two cycles after start with a cleared signature.
    num_rounds = '0; use_ext = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check("t6_busy", busy, 1);
    check("t6_done_low", done, 0);
    tick();
    check("t6_done", done, 1);
    check("t6_busy_end", busy, 0);
    check("t6_sig", signature, 0);
    check("t6_rounds", round_count, 0);
    check("t6_stage", bus.stage, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
